msrv32_trap_controller: RTL and testbench
=========================================

# msrv32_trap_controller

Machine-mode trap sequencer for the msrv32 core. Sits directly upstream of the CSR file: it consumes the interrupt-enable/pending bits the CSR file exports, watches exception flags from decode and the load/store unit, and produces the `set_cause`, `cause`, `set_epc`, `i_or_e`, `mie_clear`, `mie_set`, `instret_inc` and `misaligned_exception` strobes the CSR file acts on. It also selects the PC source and flushes the pipeline on trap entry and return.

## Interface
- Parameters: none.
- `clk_in  input  1`  core clock.
- `rst_n_in  input  1`  asynchronous, active-low reset.
- `instr_valid_in  input  1`  instruction in execute is valid this cycle.
- `ecall_in`, `ebreak_in`, `mret_in  input  1 each`  decoded system instruction in execute.
- `illegal_instr_in  input  1`  illegal opcode.
- `misaligned_instr_in`, `misaligned_load_in`, `misaligned_store_in  input  1 each`  address misalignment flags.
- `mie_in`, `meie_in`, `mtie_in`, `msie_in`, `meip_in`, `mtip_in`, `msip_in  input  1 each`  from the CSR file.
- `i_or_e_out  output  1`  1 = interrupt trap, 0 = exception.
- `set_cause_out`, `set_epc_out`, `mie_clear_out`, `mie_set_out`, `instret_inc_out`, `misaligned_exception_out  output  1 each`.
- `cause_out  output  4`  trap cause code.
- `pc_src_out  output  2`  00 boot, 01 sequential/branch, 10 mtvec, 11 mepc.
- `flush_out  output  1`  kill instruction in fetch/decode.
- `trap_taken_out  output  1`  high for the trap-entry cycle.

## Operation
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- RESET → OPERATING unconditionally on the first clock after reset release.
- In OPERATING, priority is interrupt > exception > mret > normal.
- Interrupt pending is `mie_in & ((meie_in&meip_in)|(msie_in&msip_in)|(mtie_in&mtip_in))`. Cause priority: external 11, then software 3, then timer 7.
- Exceptions are qualified by `instr_valid_in`. Priority and causes: misaligned_instr 0, illegal 2, ecall 11, ebreak 3, misaligned_load 4, misaligned_store 6.
- On any trap: capture cause and `i_or_e`, then go to TRAP_TAKEN.
- On valid mret with no trap: go to TRAP_RETURN.
- TRAP_TAKEN → OPERATING. TRAP_RETURN → OPERATING.
- In TRAP_TAKEN: `set_cause_out`, `set_epc_out`, `mie_clear_out`, `flush_out` and `trap_taken_out` are 1; `pc_src_out`=10. `misaligned_exception_out` is 1 iff the captured cause is 0, 4 or 6 and `i_or_e`=0.
- In TRAP_RETURN: `mie_set_out`=1, `flush_out`=1, `pc_src_out`=11.
- In OPERATING: `pc_src_out`=01, `flush_out`=0. `instret_inc_out` = `instr_valid_in` and no trap and no mret (trapping instructions do not retire; mret retires in TRAP_RETURN with `instret_inc_out`=1).
- In RESET: `pc_src_out`=00, `flush_out`=1.
- `cause_out` and `i_or_e_out` are registered and hold until the next trap capture.

## Timing
- Reset values: state RESET, `pc_src_out`=00, `flush_out`=1, `cause_out`=0, all other outputs 0.
- Strobe outputs decode from the state register only (Moore); no combinational path from inputs to outputs.
- Trap-detect-to-strobe latency is 1 cycle. The CSR file samples the strobes on the following edge.
- Trap entry and mret each occupy exactly 1 cycle in their state.
- Interrupts and exceptions arriving while in TRAP_TAKEN or TRAP_RETURN are not sampled. They are re-evaluated in OPERATING; interrupts are level-sensitive, so they are not lost.
- mret together with an exception in the same cycle: the exception wins; no TRAP_RETURN.
- Reset asserted mid-trap: the FSM returns immediately (asynchronously) to RESET with reset values; no partial strobes.

## Configuration
- `MSRV32_IRQ_EN` defined: interrupts are recognised as above.
- `MSRV32_IRQ_EN` undefined: the interrupt-pending term is constant 0, the `mie*`/`m*ip` inputs are ignored, and `i_or_e_out` is tied 0. Exceptions and mret are unchanged.

## Test plan
- Release reset → 1 cycle with `pc_src_out`=00 and `flush_out`=1, then `pc_src_out`=01 and `flush_out`=0.
- Valid ecall in OPERATING → next cycle: `cause_out`=11, `i_or_e_out`=0, `set_cause_out`=`set_epc_out`=`mie_clear_out`=1, `pc_src_out`=10, `instret_inc_out`=0.
- `mie_in`=1, meie/meip=1 and mtie/mtip=1 together → `cause_out`=11 and `i_or_e_out`=1. With `mie_in`=0, no trap occurs.
- misaligned_load together with illegal → `cause_out`=2 and `misaligned_exception_out`=0. misaligned_store alone → `cause_out`=6 and `misaligned_exception_out`=1.
- mret → 1 cycle with `mie_set_out`=1, `pc_src_out`=11 and `instret_inc_out`=1. mret together with ebreak → `cause_out`=3 and no `mie_set_out`.
- `rst_n_in` pulsed low during TRAP_TAKEN → outputs return to reset values immediately. Build without `MSRV32_IRQ_EN` → pending interrupts cause no trap.

Source files
------------

// File: rtl/msrv32_trap_controller.sv
// msrv32 machine-mode trap sequencer: trap entry, mret, PC select, flush.
// Optional `MSRV32_IRQ_EN enables interrupt recognition (off by default).
module msrv32_trap_controller (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       instr_valid_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       misaligned_exception_out,
  output logic [3:0] cause_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out
);

  typedef enum logic [1:0] {
    S_RESET       = 2'b00,
    S_OPERATING   = 2'b01,
    S_TRAP_TAKEN  = 2'b10,
    S_TRAP_RETURN = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic       ioe_q, ioe_d;
  logic       set_cause_q, set_cause_d;
  logic       mie_clear_q, mie_clear_d;
  logic       mie_set_q, mie_set_d;
  logic       instret_q, instret_d;
  logic       mis_q, mis_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic       flush_q, flush_d;
  logic       trap_q, trap_d;

  logic       irq;
  logic [3:0] irq_cause;
  logic       exc;
  logic [3:0] exc_cause;
  logic       ret;

`ifdef MSRV32_IRQ_EN
  // Interrupt pending and cause: external > software > timer
  always_comb begin
    irq       = mie_in & ((meie_in & meip_in) |
                          (msie_in & msip_in) |
                          (mtie_in & mtip_in));
    irq_cause = 4'd7;
    if (meie_in & meip_in)
      irq_cause = 4'd11;
    else if (msie_in & msip_in)
      irq_cause = 4'd3;
  end
`else
  logic unused_irq;
  assign unused_irq = ^{mie_in, meie_in, mtie_in, msie_in,
                        meip_in, mtip_in, msip_in};

  // Interrupts disabled: nothing is ever pending
  always_comb begin
    irq       = 1'b0;
    irq_cause = 4'd0;
  end
`endif

  // Exception detect and priority encode of the cause
  always_comb begin
    exc_cause = 4'd0;
    exc       = instr_valid_in &
                (misaligned_instr_in | illegal_instr_in |
                 ecall_in | ebreak_in |
                 misaligned_load_in | misaligned_store_in);
    if (misaligned_instr_in)
      exc_cause = 4'd0;
    else if (illegal_instr_in)
      exc_cause = 4'd2;
    else if (ecall_in)
      exc_cause = 4'd11;
    else if (ebreak_in)
      exc_cause = 4'd3;
    else if (misaligned_load_in)
      exc_cause = 4'd4;
    else if (misaligned_store_in)
      exc_cause = 4'd6;
    ret = instr_valid_in & mret_in;
  end

  // Next state, captured cause and next-state output decode
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    ioe_d       = ioe_q;
    set_cause_d = 1'b0;
    mie_clear_d = 1'b0;
    mie_set_d   = 1'b0;
    instret_d   = 1'b0;
    mis_d       = 1'b0;
    pc_src_d    = 2'b01;
    flush_d     = 1'b0;
    trap_d      = 1'b0;
    case (state_q)
      S_RESET: state_d = S_OPERATING;
      S_OPERATING: begin
        if (irq) begin
          state_d = S_TRAP_TAKEN;
          cause_d = irq_cause;
          ioe_d   = 1'b1;
        end else if (exc) begin
          state_d = S_TRAP_TAKEN;
          cause_d = exc_cause;
          ioe_d   = 1'b0;
        end else if (ret) begin
          state_d = S_TRAP_RETURN;
        end else begin
          instret_d = instr_valid_in;
        end
      end
      default: state_d = S_OPERATING;
    endcase
    case (state_d)
      S_RESET: begin
        pc_src_d = 2'b00;
        flush_d  = 1'b1;
      end
      S_TRAP_TAKEN: begin
        set_cause_d = 1'b1;
        mie_clear_d = 1'b1;
        trap_d      = 1'b1;
        flush_d     = 1'b1;
        pc_src_d    = 2'b10;
        mis_d       = ~ioe_d & ((cause_d == 4'd0) |
                                (cause_d == 4'd4) |
                                (cause_d == 4'd6));
      end
      S_TRAP_RETURN: begin
        mie_set_d = 1'b1;
        instret_d = 1'b1;
        flush_d   = 1'b1;
        pc_src_d  = 2'b11;
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_RESET;
      cause_q     <= 4'd0;
      ioe_q       <= 1'b0;
      set_cause_q <= 1'b0;
      mie_clear_q <= 1'b0;
      mie_set_q   <= 1'b0;
      instret_q   <= 1'b0;
      mis_q       <= 1'b0;
      pc_src_q    <= 2'b00;
      flush_q     <= 1'b1;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      ioe_q       <= ioe_d;
      set_cause_q <= set_cause_d;
      mie_clear_q <= mie_clear_d;
      mie_set_q   <= mie_set_d;
      instret_q   <= instret_d;
      mis_q       <= mis_d;
      pc_src_q    <= pc_src_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
    end
  end

  assign i_or_e_out               = ioe_q;
  assign set_cause_out            = set_cause_q;
  assign set_epc_out              = set_cause_q;
  assign mie_clear_out            = mie_clear_q;
  assign mie_set_out              = mie_set_q;
  assign instret_inc_out          = instret_q;
  assign misaligned_exception_out = mis_q;
  assign cause_out                = cause_q;
  assign pc_src_out               = pc_src_q;
  assign flush_out                = flush_q;
  assign trap_taken_out           = trap_q;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Directed-vector bench for msrv32_trap_controller.
// Expectations follow `MSRV32_IRQ_EN when the bench is built with it.
module tb_msrv32_trap_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, ecall, ebreak, mret, illegal;
  logic       mis_i, mis_l, mis_s;
  logic       mie, meie, mtie, msie, meip, mtip, msip;
  logic       ioe, set_cause, set_epc, mie_clear, mie_set;
  logic       instret, mis_exc, flush, trap;
  logic [3:0] cause;
  logic [1:0] pc_src;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  msrv32_trap_controller dut (
    .clk_in                   (clk),
    .rst_n_in                 (rst_n),
    .instr_valid_in           (valid),
    .ecall_in                 (ecall),
    .ebreak_in                (ebreak),
    .mret_in                  (mret),
    .illegal_instr_in         (illegal),
    .misaligned_instr_in      (mis_i),
    .misaligned_load_in       (mis_l),
    .misaligned_store_in      (mis_s),
    .mie_in                   (mie),
    .meie_in                  (meie),
    .mtie_in                  (mtie),
    .msie_in                  (msie),
    .meip_in                  (meip),
    .mtip_in                  (mtip),
    .msip_in                  (msip),
    .i_or_e_out               (ioe),
    .set_cause_out            (set_cause),
    .set_epc_out              (set_epc),
    .mie_clear_out            (mie_clear),
    .mie_set_out              (mie_set),
    .instret_inc_out          (instret),
    .misaligned_exception_out (mis_exc),
    .cause_out                (cause),
    .pc_src_out               (pc_src),
    .flush_out                (flush),
    .trap_taken_out           (trap)
  );

  task automatic check(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {valid, ecall, ebreak, mret, illegal} = '0;
    {mis_i, mis_l, mis_s} = '0;
    {mie, meie, mtie, msie, meip, mtip, msip} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    check({tag, ".pc"}, {2'b0, pc_src}, 4'h0);
    check({tag, ".flush"}, {3'b0, flush}, 4'h1);
    check({tag, ".cause"}, cause, 4'h0);
    check({tag, ".ioe"}, {3'b0, ioe}, 4'h0);
    check({tag, ".setc"}, {3'b0, set_cause}, 4'h0);
    check({tag, ".trap"}, {3'b0, trap}, 4'h0);
    check({tag, ".instret"}, {3'b0, instret}, 4'h0);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #12;
    chk_rst("rst");
    rst_n = 1'b1;
    #1;
    check("rel.pc", {2'b0, pc_src}, 4'h0);
    step();
    check("op.pc", {2'b0, pc_src}, 4'h1);
    check("op.flush", {3'b0, flush}, 4'h0);

    // plain instruction retires
    valid = 1'b1;
    step();
    check("ret.instret", {3'b0, instret}, 4'h1);
    check("ret.trap", {3'b0, trap}, 4'h0);
    valid = 1'b0;
    step();
    check("idle.instret", {3'b0, instret}, 4'h0);

    // ecall
    valid = 1'b1; ecall = 1'b1;
    step();
    check("ecall.cause", cause, 4'd11);
    check("ecall.ioe", {3'b0, ioe}, 4'h0);
    check("ecall.setc", {3'b0, set_cause}, 4'h1);
    check("ecall.epc", {3'b0, set_epc}, 4'h1);
    check("ecall.mclr", {3'b0, mie_clear}, 4'h1);
    check("ecall.pc", {2'b0, pc_src}, 4'h2);
    check("ecall.instret", {3'b0, instret}, 4'h0);
    check("ecall.flush", {3'b0, flush}, 4'h1);
    check("ecall.trap", {3'b0, trap}, 4'h1);
    check("ecall.mis", {3'b0, mis_exc}, 4'h0);
    clr();
    step();
    check("post.pc", {2'b0, pc_src}, 4'h1);
    check("post.trap", {3'b0, trap}, 4'h0);
    check("post.cause", cause, 4'd11);

    // illegal beats misaligned load
    valid = 1'b1; mis_l = 1'b1; illegal = 1'b1;
    step();
    check("ill.cause", cause, 4'd2);
    check("ill.mis", {3'b0, mis_exc}, 4'h0);
    clr();
    step();

    // misaligned store alone
    valid = 1'b1; mis_s = 1'b1;
    step();
    check("mst.cause", cause, 4'd6);
    check("mst.mis", {3'b0, mis_exc}, 4'h1);
    clr();
    step();

    // misaligned fetch beats everything
    valid = 1'b1; mis_i = 1'b1; ecall = 1'b1; ebreak = 1'b1;
    step();
    check("mif.cause", cause, 4'd0);
    check("mif.mis", {3'b0, mis_exc}, 4'h1);
    clr();
    step();

    // mret
    valid = 1'b1; mret = 1'b1;
    step();
    check("mret.mset", {3'b0, mie_set}, 4'h1);
    check("mret.pc", {2'b0, pc_src}, 4'h3);
    check("mret.instret", {3'b0, instret}, 4'h1);
    check("mret.flush", {3'b0, flush}, 4'h1);
    check("mret.setc", {3'b0, set_cause}, 4'h0);
    clr();
    step();
    check("mret2.pc", {2'b0, pc_src}, 4'h1);
    check("mret2.mset", {3'b0, mie_set}, 4'h0);

    // mret with ebreak: exception wins
    valid = 1'b1; mret = 1'b1; ebreak = 1'b1;
    step();
    check("mrbk.cause", cause, 4'd3);
    check("mrbk.mset", {3'b0, mie_set}, 4'h0);
    check("mrbk.pc", {2'b0, pc_src}, 4'h2);
    clr();
    step();

    // invalid ecall is ignored
    ecall = 1'b1;
    step();
    check("inv.trap", {3'b0, trap}, 4'h0);
    check("inv.pc", {2'b0, pc_src}, 4'h1);
    clr();

    // external + timer pending
    mie = 1'b1; meie = 1'b1; meip = 1'b1;
    mtie = 1'b1; mtip = 1'b1;
    step();
`ifdef MSRV32_IRQ_EN
    check("irq.cause", cause, 4'd11);
    check("irq.ioe", {3'b0, ioe}, 4'h1);
    check("irq.trap", {3'b0, trap}, 4'h1);
    check("irq.mis", {3'b0, mis_exc}, 4'h0);
`else
    check("noirq.trap", {3'b0, trap}, 4'h0);
    check("noirq.pc", {2'b0, pc_src}, 4'h1);
    check("noirq.ioe", {3'b0, ioe}, 4'h0);
`endif
    clr();
    step();

    // global enable off
    meie = 1'b1; meip = 1'b1;
    step();
    check("mie0.trap", {3'b0, trap}, 4'h0);
    clr();

    // software beats timer
    mie = 1'b1; msie = 1'b1; msip = 1'b1;
    mtie = 1'b1; mtip = 1'b1;
    step();
`ifdef MSRV32_IRQ_EN
    check("sw.cause", cause, 4'd3);
    check("sw.ioe", {3'b0, ioe}, 4'h1);
`else
    check("sw.trap", {3'b0, trap}, 4'h0);
`endif
    clr();
    step();

    // held request not sampled in TRAP_TAKEN
    valid = 1'b1; ecall = 1'b1;
    step();
    check("hold1.trap", {3'b0, trap}, 4'h1);
    check("hold1.ioe", {3'b0, ioe}, 4'h0);
    step();
    check("hold2.trap", {3'b0, trap}, 4'h0);
    check("hold2.pc", {2'b0, pc_src}, 4'h1);
    step();
    check("hold3.trap", {3'b0, trap}, 4'h1);
    clr();
    step();

    // async reset in TRAP_TAKEN
    valid = 1'b1; ebreak = 1'b1;
    step();
    check("rmid.trap", {3'b0, trap}, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("rmid");
    check("rmid.mclr", {3'b0, mie_clear}, 4'h0);
    check("rmid.mis", {3'b0, mis_exc}, 4'h0);
    clr();
    #1;
    rst_n = 1'b1;
    step();
    check("rmid2.pc", {2'b0, pc_src}, 4'h1);
    check("rmid2.flush", {3'b0, flush}, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
